iter_shifter: RTL and testbench

//  Multi-cycle, parametrised shift/rotate unit for the datapath ALU.
//  - Supersedes single-cycle SHR; adds SHRA, SHL, ROR, ROL.
//  - Configurable operand width and bits-per-cycle.
//  - start/busy/done handshake; result held in an internal register (Z-style) until the next accepted start.
//  - Sits beside the ALU. Y feeds operand a, the bus feeds shamt, result drives Z.

---
 rtl/iter_shifter_pkg.sv | 21 ++
 rtl/iter_shifter_if.sv | 25 ++
 rtl/iter_shifter_shift_step.sv | 64 ++++++
 rtl/iter_shifter.sv | 126 ++++++++++++
 tb/tb_iter_shifter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shift/rotate unit: opcode values,
// FSM state encoding and the opcode legality helper.
package iter_shifter_pkg;

  localparam logic [2:0] MODE_SHR  = 3'b000;
  localparam logic [2:0] MODE_SHRA = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m <= MODE_ROL);
  endfunction

endpackage

// File: rtl/iter_shifter_if.sv
// Request/result bundle of the shifter: the ALU side drives the request,
// the shifter returns handshake status and the held result.
interface iter_shifter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             last_out;
  logic             err;

  modport master (
    output start, mode, a, shamt,
    input  busy, done, result, last_out, err
  );

  modport slave (
    input  start, mode, a, shamt,
    output busy, done, result, last_out, err
  );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// Combinational single step: shifts or rotates acc by k positions and
// reports the last bit that left (or wrapped around) the word.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [SHW-1:0]   k_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             out_bit_o
);

  localparam logic [SHW:0] W_EXT = (SHW+1)'(WIDTH);

  logic [SHW:0]     k_inv;
  logic [SHW-1:0]   lo_idx;
  logic [SHW-1:0]   hi_idx;
  logic [WIDTH-1:0] rotr;
  logic [WIDTH-1:0] rotl;
  logic             k_nz;

  // k_inv is WIDTH when k==0, which shifts the wrap term fully out
  assign k_inv  = W_EXT - {1'b0, k_i};
  assign lo_idx = k_i - SHW'(1);
  assign hi_idx = SHW'(0) - k_i;
  assign rotr   = (acc_i >> k_i) | (acc_i << k_inv);
  assign rotl   = (acc_i << k_i) | (acc_i >> k_inv);
  assign k_nz   = (k_i != '0);

  always_comb begin
    acc_o     = acc_i;
    out_bit_o = 1'b0;
    case (mode_i)
      MODE_SHR: begin
        acc_o     = acc_i >> k_i;
        out_bit_o = k_nz & acc_i[lo_idx];
      end
      MODE_SHRA: begin
        acc_o     = WIDTH'($signed(acc_i) >>> k_i);
        out_bit_o = k_nz & acc_i[lo_idx];
      end
      MODE_SHL: begin
        acc_o     = acc_i << k_i;
        out_bit_o = k_nz & acc_i[hi_idx];
      end
      MODE_ROR: begin
        acc_o     = rotr;
        out_bit_o = k_nz & rotr[WIDTH-1];
      end
      MODE_ROL: begin
        acc_o     = rotl;
        out_bit_o = k_nz & rotl[0];
      end
      default: begin
        acc_o     = acc_i;
        out_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: accepts a request, walks the operand
// STEP positions per cycle, then presents a held result with a done pulse.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_shifter_if.slave bus
);

  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic             ill_q, ill_d;
  logic             lb_q, lb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             last_out_q, last_out_d;
  logic             err_q, err_d;

  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] step_acc;
  logic             step_bit;
  logic             unused_shamt_hi;

  assign unused_shamt_hi = ^bus.shamt[WIDTH-1:SHW];
  assign k = (rem_q < STEP_W) ? rem_q : STEP_W;

  shift_step #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_step (
    .acc_i     (acc_q),
    .k_i       (k),
    .mode_i    (mode_q),
    .acc_o     (step_acc),
    .out_bit_o (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      mode_q     <= MODE_SHR;
      ill_q      <= 1'b0;
      lb_q       <= 1'b0;
      result_q   <= '0;
      last_out_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      ill_q      <= ill_d;
      lb_q       <= lb_d;
      result_q   <= result_d;
      last_out_q <= last_out_d;
      err_q      <= err_d;
    end
  end

  // Every accepted request passes through RUN; the final RUN cycle with
  // rem==0 commits the result, giving latency ceil(n/STEP)+1 (1 for n==0
  // or an illegal opcode).
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    ill_d      = ill_q;
    lb_d       = lb_q;
    result_d   = result_q;
    last_out_d = last_out_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = bus.a;
          mode_d  = bus.mode;
          lb_d    = 1'b0;
          state_d = S_RUN;
          if (mode_legal(bus.mode)) begin
            ill_d = 1'b0;
            rem_d = bus.shamt[SHW-1:0];
          end else begin
            ill_d = 1'b1;
            rem_d = '0;
          end
        end
      end
      S_RUN: begin
        if (rem_q == '0) begin
          result_d   = acc_q;
          last_out_d = lb_q;
          err_d      = ill_q;
          state_d    = S_DONE;
        end else begin
          acc_d = step_acc;
          lb_d  = step_bit;
          rem_d = rem_q - k;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.last_out = last_out_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: a STEP=1 and a STEP=4 instance checked
// against hand-computed results, latencies and handshake behaviour.
module tb_iter_shifter;
  import iter_shifter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic        sel4;
  logic [2:0]  mode_v;
  logic [31:0] a_v;
  logic [31:0] shamt_v;
  int          pass_cnt;
  int          chk_cnt;
  int          done_cnt;

  iter_shifter_if #(.WIDTH(32)) bus1 ();
  iter_shifter_if #(.WIDTH(32)) bus4 ();

  assign bus1.start = go & ~sel4;
  assign bus4.start = go & sel4;
  assign bus1.mode  = mode_v;
  assign bus4.mode  = mode_v;
  assign bus1.a     = a_v;
  assign bus4.a     = a_v;
  assign bus1.shamt = shamt_v;
  assign bus4.shamt = shamt_v;

  logic        busy_m, done_m, last_m, err_m;
  logic [31:0] result_m;
  assign busy_m   = sel4 ? bus4.busy     : bus1.busy;
  assign done_m   = sel4 ? bus4.done     : bus1.done;
  assign last_m   = sel4 ? bus4.last_out : bus1.last_out;
  assign err_m    = sel4 ? bus4.err      : bus1.err;
  assign result_m = sel4 ? bus4.result   : bus1.result;

  iter_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  iter_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One request: accept edge is edge 0; done must appear right after edge exp_l.
  task automatic run_op(input bit s4, input logic [2:0] m, input logic [31:0] av,
                        input logic [31:0] sv, input int exp_l, input logic [31:0] exp_r,
                        input logic exp_lo, input logic exp_err, input string tag);
    int seen;
    seen    = -1;
    sel4    = s4;
    mode_v  = m;
    a_v     = av;
    shamt_v = sv;
    go      = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    check({tag, " busy@0"}, 32'(busy_m), 32'd1);
    for (int i = 1; i <= 40 && seen < 0; i++) begin
      @(posedge clk);
      #1;
      if (done_m) seen = i;
      else check({tag, " busy@run"}, 32'(busy_m), 32'd1);
    end
    check({tag, " latency"}, 32'(seen), 32'(exp_l));
    if (seen >= 0) begin
      check({tag, " busy@done"}, 32'(busy_m), 32'd1);
      check({tag, " result"}, result_m, exp_r);
      check({tag, " last_out"}, 32'(last_m), 32'(exp_lo));
      check({tag, " err"}, 32'(err_m), 32'(exp_err));
    end
    @(posedge clk);
    #1;
    check({tag, " done_clr"}, 32'(done_m), 32'd0);
    check({tag, " idle"}, 32'(busy_m), 32'd0);
    $display("op %s: step=%0d mode=%b a=%h shamt=%h -> result=%h last=%b err=%b after edge %0d",
             tag, s4 ? 4 : 1, m, av, sv, result_m, last_m, err_m, seen);
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    done_cnt = 0;
    go       = 1'b0;
    sel4     = 1'b0;
    mode_v   = MODE_SHR;
    a_v      = '0;
    shamt_v  = '0;
    rst_n    = 1'b0;

    #12;
    check("rst busy",   32'(busy_m),  32'd0);
    check("rst done",   32'(done_m),  32'd0);
    check("rst result", result_m,     32'd0);
    check("rst last",   32'(last_m),  32'd0);
    check("rst err",    32'(err_m),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, MODE_SHR,  32'h8000_0012, 32'd4,      5, 32'h0800_0001, 1'b0, 1'b0, "shr");
    run_op(1'b0, MODE_SHR,  32'h0000_0008, 32'd4,      5, 32'h0000_0000, 1'b1, 1'b0, "shr_last1");
    run_op(1'b0, MODE_SHRA, 32'h8000_0000, 32'h24,     5, 32'hF800_0000, 1'b0, 1'b0, "shra");
    run_op(1'b0, MODE_ROL,  32'h8000_0001, 32'd1,      2, 32'h0000_0003, 1'b1, 1'b0, "rol");
    run_op(1'b0, MODE_ROR,  32'h0000_0001, 32'd1,      2, 32'h8000_0000, 1'b1, 1'b0, "ror1");
    run_op(1'b0, MODE_ROR,  32'h1234_5678, 32'd32,     1, 32'h1234_5678, 1'b0, 1'b0, "ror_w");
    run_op(1'b1, MODE_SHL,  32'h0000_0001, 32'd10,     4, 32'h0000_0400, 1'b0, 1'b0, "shl_s4");
    run_op(1'b1, MODE_ROR,  32'h0000_0012, 32'd4,      2, 32'h2000_0001, 1'b0, 1'b0, "ror_s4");

    // Extra starts during RUN and during DONE must be dropped.
    sel4    = 1'b0;
    mode_v  = MODE_SHR;
    a_v     = 32'h0000_00F0;
    shamt_v = 32'd4;
    go      = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        mode_v  = MODE_SHL;
        a_v     = 32'h0000_0001;
        shamt_v = 32'd1;
        go      = 1'b1;
      end
      @(posedge clk);
      #1 go = 1'b0;
      if (done_m) begin
        done_cnt++;
        if (done_cnt == 1) go = 1'b1;
      end
    end
    check("ignore done_count", 32'(done_cnt), 32'd1);
    check("ignore result",     result_m,      32'h0000_000F);
    check("ignore idle",       32'(busy_m),   32'd0);
    $display("op ignore: dones=%0d result=%h", done_cnt, result_m);
    run_op(1'b0, MODE_SHL, 32'h0000_0001, 32'd1, 2, 32'h0000_0002, 1'b0, 1'b0, "after_ignore");

    run_op(1'b0, MODE_SHR, 32'hDEAD_BEEF, 32'd0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, "n0");
    run_op(1'b0, 3'b110,   32'hDEAD_BEEF, 32'd5, 1, 32'hDEAD_BEEF, 1'b0, 1'b1, "illegal");

    // Asynchronous reset between edges while a long shift is running.
    sel4    = 1'b0;
    mode_v  = MODE_SHR;
    a_v     = 32'hFFFF_0000;
    shamt_v = 32'd20;
    go      = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst busy",   32'(busy_m), 32'd0);
    check("arst done",   32'(done_m), 32'd0);
    check("arst err",    32'(err_m),  32'd0);
    check("arst result", result_m,    32'd0);
    check("arst last",   32'(last_m), 32'd0);
    $display("op arst: busy=%b done=%b err=%b result=%h", busy_m, done_m, err_m, result_m);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, MODE_SHL, 32'h0000_0003, 32'd2, 3, 32'h0000_000C, 1'b0, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
